// File: rtl/gp_apb_to_axis_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : gp_apb_to_axis_bridge_if
// Description : APB3 completer bus plus AXI-Stream request/response channels.
// Revision    : 1.0
// ============================================================================
interface gp_apb_to_axis_bridge_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) ();
    logic [APB_ADDR_WIDTH-1:0] paddr_i;
    logic [APB_DATA_WIDTH-1:0] pwdata_i;
    logic                      pwrite_i;
    logic                      psel_i;
    logic                      penable_i;
    logic [APB_DATA_WIDTH-1:0] prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    logic [APB_DATA_WIDTH-1:0] req_tdata_o;
    logic [APB_ADDR_WIDTH:0]   req_tuser_o;
    logic                      req_tvalid_o;
    logic                      req_tready_i;

    logic [APB_DATA_WIDTH-1:0] rsp_tdata_i;
    logic                      rsp_tuser_i;
    logic                      rsp_tvalid_i;
    logic                      rsp_tready_o;

    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o,
        input  req_tdata_o, req_tuser_o, req_tvalid_o,
        output req_tready_i,
        output rsp_tdata_i, rsp_tuser_i, rsp_tvalid_i,
        input  rsp_tready_o
    );

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o,
        output req_tdata_o, req_tuser_o, req_tvalid_o,
        input  req_tready_i,
        input  rsp_tdata_i, rsp_tuser_i, rsp_tvalid_i,
        output rsp_tready_o
    );
endinterface
`default_nettype wire

// File: rtl/gp_apb_to_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module      : gp_apb_to_axis_bridge
// Description : APB3 completer tunnelled over an AXI-Stream request/response
//               pair, one access at a time, with timeout and late-beat discard.
// Revision    : 1.0
// ============================================================================
module gp_apb_to_axis_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DROP_CNT_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    gp_apb_to_axis_bridge_if.slave bus,
    output logic                   timeout_o
);
    localparam int TO_CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_CNT_W-1:0] C_TO_LAST = TO_CNT_W'(TO_LAST_INT);
    localparam bit C_TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      state_q,     state_d;
    logic [APB_DATA_WIDTH-1:0]   req_tdata_q, req_tdata_d;
    logic [APB_ADDR_WIDTH:0]     req_tuser_q, req_tuser_d;
    logic [APB_DATA_WIDTH-1:0]   prdata_q,    prdata_d;
    logic                        pslverr_q,   pslverr_d;
    logic                        timeout_q,   timeout_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q,  drop_cnt_d;
    logic [TO_CNT_W-1:0]         to_cnt_q,    to_cnt_d;

    logic w_drop_active;
    logic w_drop_sat;
    logic w_rsp_ready;
    logic w_rsp_hs;
    logic w_accept;
    logic w_discard;
    logic w_expired;
    logic w_timeout;

    assign w_drop_active = (drop_cnt_q != '0);
    assign w_drop_sat    = &drop_cnt_q;
    // Stale beats must drain before the current response may be accepted.
    assign w_rsp_ready   = w_drop_active || (state_q == S_RSP);
    assign w_rsp_hs      = w_rsp_ready && bus.rsp_tvalid_i;
    assign w_discard     = w_rsp_hs && w_drop_active;
    assign w_accept      = w_rsp_hs && !w_drop_active;
    assign w_expired     = C_TO_EN && (state_q == S_RSP) && (to_cnt_q == C_TO_LAST);
    assign w_timeout     = w_expired && !w_rsp_hs && !w_drop_sat;

    always_comb begin
        state_d     = state_q;
        req_tdata_d = req_tdata_q;
        req_tuser_d = req_tuser_q;
        prdata_d    = prdata_q;
        pslverr_d   = pslverr_q;
        timeout_d   = 1'b0;
        to_cnt_d    = to_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.psel_i && !bus.penable_i) begin
                    req_tdata_d = bus.pwdata_i;
                    req_tuser_d = {bus.pwrite_i, bus.paddr_i};
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.req_tready_i) begin
                    to_cnt_d = '0;
                    state_d  = S_RSP;
                end
            end
            S_RSP: begin
                if (w_accept) begin
                    pslverr_d = bus.rsp_tuser_i;
                    prdata_d  = req_tuser_q[APB_ADDR_WIDTH] ? '0 : bus.rsp_tdata_i;
                    state_d   = S_DONE;
                end else if (w_timeout) begin
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else if (C_TO_EN && (to_cnt_q != C_TO_LAST)) begin
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timeout never coincides with a handshake, so the two are exclusive.
        if (w_timeout) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end else if (w_discard) begin
            drop_cnt_d = drop_cnt_q - DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            req_tdata_q <= '0;
            req_tuser_q <= '0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            timeout_q   <= 1'b0;
            drop_cnt_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_tdata_q <= req_tdata_d;
            req_tuser_q <= req_tuser_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            timeout_q   <= timeout_d;
            drop_cnt_q  <= drop_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.prdata_o     = prdata_q;
    assign bus.pslverr_o    = pslverr_q;
    assign bus.pready_o     = (state_q == S_DONE);
    assign bus.req_tdata_o  = req_tdata_q;
    assign bus.req_tuser_o  = req_tuser_q;
    assign bus.req_tvalid_o = (state_q == S_REQ);
    assign bus.rsp_tready_o = w_rsp_ready;
    assign timeout_o        = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_gp_apb_to_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_apb_to_axis_bridge
// Description : Table-driven and randomized bench for the APB-to-AXIS bridge.
// Revision    : 1.0
// ============================================================================
module tb_gp_apb_to_axis_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int NO_RSP = 1000;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            stall;
        int            delay;
        logic [DW-1:0] rdata;
        logic          rerr;
        logic [DW-1:0] exp_prdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timeout;
    int   n_checks = 0;
    int   n_errors = 0;

    gp_apb_to_axis_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus_if ();

    gp_apb_to_axis_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO),
        .DROP_CNT_WIDTH(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus_if),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({bus_if.req_tvalid_o, bus_if.rsp_tready_o, bus_if.pready_o,
                                   bus_if.pslverr_o, timeout}), 64'd0);
        check({tag, "_req_tdata"}, 64'(bus_if.req_tdata_o), 64'd0);
        check({tag, "_req_tuser"}, 64'(bus_if.req_tuser_o), 64'd0);
        check({tag, "_prdata"}, 64'(bus_if.prdata_o), 64'd0);
    endtask

    // Reference model: one request, response after 'delay' cycles unless it
    // misses the TO-cycle window, in which case the access fails with zero data.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_to     = (v.delay >= TO);
        r.exp_err    = r.exp_to ? 1'b1 : v.rerr;
        r.exp_prdata = (r.exp_to || v.wr) ? '0 : v.rdata;
        r.exp_lat    = 1 + v.stall + (r.exp_to ? TO : v.delay + 1) + 1;
        return r;
    endfunction

    task automatic run_access(input vec_t v);
        int   n;
        int   bad;
        logic rsp_done;
        logic ready_seen;
        logic done;
        bad        = 0;
        rsp_done   = 1'b0;
        ready_seen = 1'b0;
        done       = 1'b0;
        @(negedge clk);
        bus_if.psel_i       = 1'b1;
        bus_if.penable_i    = 1'b0;
        bus_if.paddr_i      = v.addr;
        bus_if.pwdata_i     = v.wdata;
        bus_if.pwrite_i     = v.wr;
        bus_if.req_tready_i = 1'b0;
        bus_if.rsp_tvalid_i = 1'b0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            n = c;
            bus_if.penable_i = 1'b1;
            if (n <= v.stall + 1) begin
                if (!(bus_if.req_tvalid_o && bus_if.req_tdata_o == v.wdata &&
                      bus_if.req_tuser_o == {v.wr, v.addr})) bad++;
            end else if (bus_if.req_tvalid_o) begin
                bad++;
            end
            if (timeout && !bus_if.pready_o) bad++;
            bus_if.req_tready_i = (n >= v.stall + 1);
            if (bus_if.rsp_tvalid_i && ready_seen) begin
                bus_if.rsp_tvalid_i = 1'b0;
                rsp_done = 1'b1;
            end else if (!rsp_done && v.delay < TO && n == v.stall + 2 + v.delay) begin
                bus_if.rsp_tvalid_i = 1'b1;
                bus_if.rsp_tdata_i  = v.rdata;
                bus_if.rsp_tuser_i  = v.rerr;
            end
            ready_seen = bus_if.rsp_tvalid_i && bus_if.rsp_tready_o;
            if (bus_if.pready_o) begin
                done = 1'b1;
                check("latency", 64'(n), 64'(v.exp_lat));
                check("prdata", 64'(bus_if.prdata_o), 64'(v.exp_prdata));
                check("pslverr", 64'(bus_if.pslverr_o), 64'(v.exp_err));
                check("timeout_pulse", 64'(timeout), 64'(v.exp_to));
            end
        end
        if (!done) check("pready_wait", 64'd0, 64'd1);
        check("req_stable", 64'(bad), 64'd0);
        @(negedge clk);
        bus_if.psel_i       = 1'b0;
        bus_if.penable_i    = 1'b0;
        bus_if.req_tready_i = 1'b0;
        bus_if.rsp_tvalid_i = 1'b0;
        check("pready_one_cycle", 64'(bus_if.pready_o), 64'd0);
        check("drop_state", 64'(bus_if.rsp_tready_o), 64'(v.exp_to));
    endtask

    task automatic reset_mid_access(input logic in_rsp);
        @(negedge clk);
        bus_if.psel_i       = 1'b1;
        bus_if.penable_i    = 1'b0;
        bus_if.pwrite_i     = 1'b1;
        bus_if.paddr_i      = 32'h0000_0F00;
        bus_if.pwdata_i     = 32'h7777_8888;
        bus_if.req_tready_i = in_rsp;
        @(negedge clk);
        bus_if.penable_i = 1'b1;
        check(in_rsp ? "pre_rst_tvalid_rsp" : "pre_rst_tvalid_req",
              64'(bus_if.req_tvalid_o), 64'd1);
        repeat (3) @(negedge clk);
        check(in_rsp ? "pre_rst_rsp_ready" : "pre_rst_req_valid",
              64'(in_rsp ? bus_if.rsp_tready_o : bus_if.req_tvalid_o), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs(in_rsp ? "async_rst_rsp" : "async_rst_req");
        bus_if.psel_i       = 1'b0;
        bus_if.penable_i    = 1'b0;
        bus_if.req_tready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[7];
    vec_t v;

    initial begin
        bus_if.paddr_i      = '0;
        bus_if.pwdata_i     = '0;
        bus_if.pwrite_i     = 1'b0;
        bus_if.psel_i       = 1'b0;
        bus_if.penable_i    = 1'b0;
        bus_if.req_tready_i = 1'b0;
        bus_if.rsp_tdata_i  = '0;
        bus_if.rsp_tuser_i  = 1'b0;
        bus_if.rsp_tvalid_i = 1'b0;

        //           wr    addr          wdata         stall delay   rdata         rerr  exp_prdata    err   to    lat
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 0,      32'h0BAD_0BAD, 1'b0, 32'h0,        1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         0, 0,      32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         5, 0,      32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         0, 0,      32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 3};
        vecs[4] = '{1'b1, 32'h0000_0034, 32'h1234_5678, 0, 2,      32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 1'b0, 5};
        vecs[5] = '{1'b0, 32'h0000_0038, 32'h0,         1, 15,     32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 19};
        vecs[6] = '{1'b0, 32'h0000_003C, 32'h0,         0, NO_RSP, 32'h0,         1'b0, 32'h0,        1'b1, 1'b1, 18};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_access(vecs[i]);
        end

        // The timed-out access leaves one stale beat to be swallowed.
        @(negedge clk);
        bus_if.rsp_tvalid_i = 1'b1;
        bus_if.rsp_tdata_i  = 32'hBADB_ADBA;
        bus_if.rsp_tuser_i  = 1'b0;
        check("late_ready", 64'(bus_if.rsp_tready_o), 64'd1);
        @(negedge clk);
        bus_if.rsp_tvalid_i = 1'b0;
        check("drop_cleared", 64'(bus_if.rsp_tready_o), 64'd0);
        v = '{1'b0, 32'h0000_0040, 32'h0, 0, 1, 32'h1111_2222, 1'b0, 32'h0, 1'b0, 1'b0, 0};
        run_access(model(v));

        for (int i = 0; i < 20; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.stall = $urandom_range(0, 3);
            v.delay = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
            v.rdata = $urandom;
            v.rerr  = ($urandom_range(0, 7) == 0);
            run_access(model(v));
        end

        reset_mid_access(1'b0);
        reset_mid_access(1'b1);
        v = '{1'b1, 32'h0000_0044, 32'hFEED_F00D, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0};
        run_access(model(v));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
